// File: rtl/cmp_minmax_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_minmax_scan_pkg
// Brief    : State encoding shared by the min/max scan engine.
// Revision : 1.0  initial release
// ============================================================================
package cmp_minmax_scan_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_CMP_MIN = 3'd2,
        ST_CMP_MAX = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cmp_minmax_scan_cmpzelg.sv
`default_nettype none
// ============================================================================
// Module   : CmpZelg
// Brief    : Unsigned magnitude comparator of x against y.
// Revision : 1.0  initial release
// ============================================================================
module CmpZelg #(
    parameter int p_WIDTH = 8
) (
    input  logic [p_WIDTH-1:0] iv_x,
    input  logic [p_WIDTH-1:0] iv_y,
    output logic               o_less,
    output logic               o_greater,
    output logic               o_equal,
    output logic               o_zero
);

    assign o_less    = (iv_x <  iv_y);
    assign o_greater = (iv_x >  iv_y);
    assign o_equal   = (iv_x == iv_y);
    assign o_zero    = (iv_x == '0);

endmodule
`default_nettype wire

// File: rtl/cmp_minmax_scan.sv
`default_nettype none
// ============================================================================
// Module   : cmp_minmax_scan
// Brief    : Sequential min/max search sharing one CmpZelg across a stream.
//            Define CMP_MINMAX_IDX_EN to keep first-occurrence index outputs.
// Revision : 1.0  initial release
// ============================================================================
module cmp_minmax_scan
    import cmp_minmax_scan_pkg::*;
#(
    parameter int p_WIDTH     = 8,
    parameter int p_CNT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [p_CNT_WIDTH-1:0] iv_len,
    input  logic                   i_valid,
    input  logic [p_WIDTH-1:0]     iv_data,
    output logic                   o_ready,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_empty,
    output logic [p_WIDTH-1:0]     ov_min,
    output logic [p_WIDTH-1:0]     ov_max,
    output logic [p_CNT_WIDTH-1:0] ov_min_idx,
    output logic [p_CNT_WIDTH-1:0] ov_max_idx
);

    localparam logic [p_CNT_WIDTH-1:0] c_CNT_ONE = p_CNT_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [p_CNT_WIDTH-1:0]   len_q, len_d;
    logic [p_CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [p_WIDTH-1:0]       data_q, data_d;
    logic [p_WIDTH-1:0]       min_q, min_d;
    logic [p_WIDTH-1:0]       max_q, max_d;
    logic                     empty_q, empty_d;
`ifdef CMP_MINMAX_IDX_EN
    logic [p_CNT_WIDTH-1:0]   min_idx_q, min_idx_d;
    logic [p_CNT_WIDTH-1:0]   max_idx_q, max_idx_d;
`endif

    logic [p_WIDTH-1:0]       cmp_y;
    logic                     cmp_less;
    logic                     cmp_greater;
    logic                     cmp_equal_unused;
    logic                     cmp_zero_unused;

    // One comparator serves both passes; y follows the running result under test.
    assign cmp_y = (state_q == ST_CMP_MAX) ? max_q : min_q;

    CmpZelg #(
        .p_WIDTH (p_WIDTH)
    ) u_cmp (
        .iv_x      (data_q),
        .iv_y      (cmp_y),
        .o_less    (cmp_less),
        .o_greater (cmp_greater),
        .o_equal   (cmp_equal_unused),
        .o_zero    (cmp_zero_unused)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        min_d   = min_q;
        max_d   = max_q;
        empty_d = empty_q;
`ifdef CMP_MINMAX_IDX_EN
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    len_d   = iv_len;
                    cnt_d   = '0;
                    empty_d = 1'b0;
                    if (iv_len == '0) begin
                        empty_d = 1'b1;
                        min_d   = '0;
                        max_d   = '0;
`ifdef CMP_MINMAX_IDX_EN
                        min_idx_d = '0;
                        max_idx_d = '0;
`endif
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (i_valid) begin
                    if (cnt_q == '0) begin
                        // First element seeds both results without a compare.
                        min_d = iv_data;
                        max_d = iv_data;
`ifdef CMP_MINMAX_IDX_EN
                        min_idx_d = '0;
                        max_idx_d = '0;
`endif
                        cnt_d   = c_CNT_ONE;
                        state_d = (len_q == c_CNT_ONE) ? ST_DONE : ST_LOAD;
                    end else begin
                        data_d  = iv_data;
                        state_d = ST_CMP_MIN;
                    end
                end
            end
            ST_CMP_MIN: begin
                if (cmp_less) begin
                    min_d = data_q;
`ifdef CMP_MINMAX_IDX_EN
                    min_idx_d = cnt_q;
`endif
                end
                state_d = ST_CMP_MAX;
            end
            ST_CMP_MAX: begin
                if (cmp_greater) begin
                    max_d = data_q;
`ifdef CMP_MINMAX_IDX_EN
                    max_idx_d = cnt_q;
`endif
                end
                cnt_d   = cnt_q + c_CNT_ONE;
                state_d = ((cnt_q + c_CNT_ONE) == len_q) ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            min_q   <= '0;
            max_q   <= '0;
            empty_q <= 1'b0;
`ifdef CMP_MINMAX_IDX_EN
            min_idx_q <= '0;
            max_idx_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            min_q   <= min_d;
            max_q   <= max_d;
            empty_q <= empty_d;
`ifdef CMP_MINMAX_IDX_EN
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
`endif
        end
    end

    assign o_ready = (state_q == ST_LOAD);
    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = (state_q == ST_DONE);
    assign o_empty = empty_q;
    assign ov_min  = min_q;
    assign ov_max  = max_q;
`ifdef CMP_MINMAX_IDX_EN
    assign ov_min_idx = min_idx_q;
    assign ov_max_idx = max_idx_q;
`else
    assign ov_min_idx = '0;
    assign ov_max_idx = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cmp_minmax_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_minmax_scan
// Brief    : Scoreboard bench for cmp_minmax_scan (index checks follow
//            CMP_MINMAX_IDX_EN).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cmp_minmax_scan;

    localparam int W  = 8;
    localparam int CW = 8;
`ifdef CMP_MINMAX_IDX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [CW-1:0] iv_len = '0;
    logic          i_valid = 1'b0;
    logic [W-1:0]  iv_data = '0;
    logic          o_ready, o_busy, o_done, o_empty;
    logic [W-1:0]  ov_min, ov_max;
    logic [CW-1:0] ov_min_idx, ov_max_idx;

    cmp_minmax_scan #(
        .p_WIDTH     (W),
        .p_CNT_WIDTH (CW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .iv_len     (iv_len),
        .i_valid    (i_valid),
        .iv_data    (iv_data),
        .o_ready    (o_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_empty    (o_empty),
        .ov_min     (ov_min),
        .ov_max     (ov_max),
        .ov_min_idx (ov_min_idx),
        .ov_max_idx (ov_max_idx)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0]  mn;
        logic [W-1:0]  mx;
        logic [CW-1:0] mn_idx;
        logic [CW-1:0] mx_idx;
        logic          empty;
        int            cycles;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] stim [0:31];

    function automatic logic [CW-1:0] idx_of(input int i);
        return IDX_EN ? CW'(i) : '0;
    endfunction

    // Reference: strict compares keep the first occurrence of each extreme.
    function automatic exp_t model(input int len, input bit cont);
        exp_t e;
        e.mn = '0; e.mx = '0; e.mn_idx = '0; e.mx_idx = '0;
        e.empty  = (len == 0);
        e.cycles = !cont ? -1 : ((len == 0) ? 1 : 3 * len - 1);
        if (len > 0) begin
            e.mn = stim[0];
            e.mx = stim[0];
            for (int i = 1; i < len; i++) begin
                if (stim[i] < e.mn) begin e.mn = stim[i]; e.mn_idx = idx_of(i); end
                if (stim[i] > e.mx) begin e.mx = stim[i]; e.mx_idx = idx_of(i); end
            end
        end
        return e;
    endfunction

    // Drives one scan; cycles counts edges from the start edge (1) to o_done.
    task automatic do_scan(input int len, input int gap, input bit pulse,
                           output int cycles, output bit done_seen, output int consumed);
        int idx;
        int gapcnt;
        bit xfer;
        idx = 0; gapcnt = 0; cycles = 0; done_seen = 1'b0;
        i_start = 1'b1;
        iv_len  = CW'(len);
        iv_data = stim[0];
        i_valid = (len > 0);
        while (!done_seen && cycles < 300) begin
            xfer = o_ready && i_valid;
            @(posedge i_clk); #1;
            cycles++;
            i_start = pulse && (cycles == 4 || cycles == 7);
            if (xfer) begin
                idx++;
                gapcnt = gap;
            end else if (gapcnt > 0) begin
                gapcnt--;
            end
            i_valid = (idx < len) && (gapcnt == 0);
            iv_data = (idx < len) ? stim[idx] : '0;
            if (o_done) done_seen = 1'b1;
        end
        i_start  = 1'b0;
        i_valid  = 1'b0;
        consumed = idx;
    endtask

    task automatic test_scan(input string name, input int len, input int gap, input bit pulse);
        exp_t e;
        int   cyc;
        int   cons;
        bit   ds;
        sb.push_back(model(len, gap == 0));
        do_scan(len, gap, pulse, cyc, ds, cons);
        e = sb.pop_front();
        checks++;
        if (!ds) begin
            failures++;
            $display("FAIL %s_done_timeout: got no o_done within %0d cycles, required o_done", name, cyc);
        end else begin
            if (e.cycles >= 0) begin
                checks++;
                if (cyc !== e.cycles) begin
                    failures++;
                    $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc, e.cycles);
                end
            end
            checks++;
            if (ov_min !== e.mn) begin
                failures++;
                $display("FAIL %s_min: got %0h, required %0h", name, ov_min, e.mn);
            end
            checks++;
            if (ov_max !== e.mx) begin
                failures++;
                $display("FAIL %s_max: got %0h, required %0h", name, ov_max, e.mx);
            end
            checks++;
            if (ov_min_idx !== e.mn_idx || ov_max_idx !== e.mx_idx) begin
                failures++;
                $display("FAIL %s_idx: got min_idx=%0d max_idx=%0d, required %0d/%0d",
                         name, ov_min_idx, ov_max_idx, e.mn_idx, e.mx_idx);
            end
            checks++;
            if (o_empty !== e.empty) begin
                failures++;
                $display("FAIL %s_empty: got %b, required %b", name, o_empty, e.empty);
            end
            checks++;
            if (cons !== len) begin
                failures++;
                $display("FAIL %s_consumed: got %0d elements taken, required %0d", name, cons, len);
            end
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse: got done=%b busy=%b after pulse, required 0/0", name, o_done, o_busy);
        end
        checks++;
        if (ov_min !== e.mn || ov_max !== e.mx) begin
            failures++;
            $display("FAIL %s_hold: got min=%0h max=%0h, required %0h/%0h", name, ov_min, ov_max, e.mn, e.mx);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if ({o_ready, o_busy, o_done, o_empty, ov_min, ov_max, ov_min_idx, ov_max_idx} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ready=%b busy=%b done=%b empty=%b min=%0h max=%0h, required all 0",
                     o_ready, o_busy, o_done, o_empty, ov_min, ov_max);
        end
        i_rst = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_basic();
        stim[0] = 8'd5; stim[1] = 8'd2; stim[2] = 8'd9; stim[3] = 8'd2;
        test_scan("len4", 4, 0, 1'b0);
        stim[0] = 8'd7;
        test_scan("len1", 1, 0, 1'b0);
    endtask

    task automatic test_empty();
        test_scan("len0", 0, 0, 1'b0);
        stim[0] = 8'd40; stim[1] = 8'd30;
        test_scan("len2_after_empty", 2, 0, 1'b0);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 3; i++) stim[i] = 8'hFF;
        test_scan("gaps_ff", 3, 2, 1'b1);
    endtask

    task automatic test_reset_mid();
        i_start = 1'b1; iv_len = CW'(3); i_valid = 1'b1; iv_data = 8'd5;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        iv_data = 8'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0 || ov_min !== 8'd5) begin
            failures++;
            $display("FAIL mid_pre_reset: got busy=%b ready=%b min=%0h, required 1/0/5", o_busy, o_ready, ov_min);
        end
        i_rst = 1'b1;
        #2;
        checks++;
        if ({o_ready, o_busy, o_done, o_empty, ov_min, ov_max, ov_min_idx, ov_max_idx} !== '0) begin
            failures++;
            $display("FAIL mid_async_reset: got busy=%b done=%b min=%0h max=%0h, required all 0",
                     o_busy, o_done, ov_min, ov_max);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (3) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_no_done: got done=%b busy=%b, required 0/0", o_done, o_busy);
            end
        end
        stim[0] = 8'd1; stim[1] = 8'd0;
        test_scan("post_reset", 2, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int lens [3] = '{5, 9, 20};
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < lens[s]; i++) stim[i] = W'($urandom_range(0, 15) * 16);
            test_scan($sformatf("b2b%0d", s), lens[s], 0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cmp_minmax_scan.md
# cmp_minmax_scan

Sequential min/max search engine that time-shares one `CmpZelg` comparator across a stream of operands. A scan is launched with a length, accepts that many values over a valid/ready handshake, and reports the minimum, maximum and (optionally) their first-occurrence indices. It sits in the ALU library beside `CmpZelg` and is the sequencing controller for it.

## Interface
- `p_WIDTH`, 8: operand width, passed to `CmpZelg.p_WIDTH`
- `p_CNT_WIDTH`, 8: width of length and index fields; max scan length 2^p_CNT_WIDTH − 1
- `i_clk`  in  1  clock, rising edge
- `i_rst`  in  1  reset, asynchronous, active-high
- `i_start`  in  1  launch a scan; sampled only in IDLE
- `iv_len`  in  p_CNT_WIDTH  element count, sampled with `i_start`
- `i_valid`  in  1  `iv_data` valid
- `iv_data`  in  p_WIDTH  operand
- `o_ready`  out  1  engine accepts `iv_data` this cycle
- `o_busy`  out  1  scan in progress (state ≠ IDLE)
- `o_done`  out  1  one-cycle pulse, results valid
- `o_empty`  out  1  last scan had length 0
- `ov_min`, `ov_max`  out  p_WIDTH  results, held until next start
- `ov_min_idx`, `ov_max_idx`  out  p_CNT_WIDTH  first-occurrence indices

## Operation
- States: IDLE, LOAD, CMP_MIN, CMP_MAX, DONE.
- IDLE: `i_start`=1 → latch `iv_len`, clear element counter, clear `o_empty`; go LOAD, or DONE with `o_empty`=1, min/max/indices cleared to 0 if `iv_len`=0.
- LOAD: `o_ready`=1. Transfer on `i_valid & o_ready` at the rising edge. First element (counter=0): written directly to min and max, indices 0; counter++; go DONE if len=1, else stay LOAD. Later elements: captured into data register, go CMP_MIN.
- CMP_MIN: comparator x=data, y=min; `o_less` → min←data, min_idx←counter. Go CMP_MAX.
- CMP_MAX: x=data, y=max; `o_greater` → max←data, max_idx←counter. Counter++; go DONE if counter+1=len, else LOAD.
- DONE: `o_done`=1 for exactly one cycle, return IDLE.
- Ties use strict compare: equal values never update, so indices report the first occurrence.
- `i_start` outside IDLE is ignored; `i_valid` outside LOAD is ignored (data not consumed).
- Unsigned arithmetic throughout; counter never wraps because len ≤ 2^p_CNT_WIDTH − 1.

## Timing
- All outputs reset to 0; state IDLE.
- Reset mid-scan: immediate abort, all outputs 0; no `o_done`.
- `o_ready`, `o_busy`, `o_done` are decoded from registered state (no combinational path from inputs).
- Per element: first element 1 cycle, each later element 3 cycles (LOAD, CMP_MIN, CMP_MAX) with `i_valid` held high.
- Scan of N≥1 with continuous valid: start edge → LOAD; `o_done` asserted 1+3(N−1)+1 cycles after the start edge. N=0: `o_done` the cycle after start.
- Results update at clock edges only and are stable whenever `o_done`=1.

## Configuration
- `CMP_MINMAX_IDX_EN` defined: index registers and updates present as above.
- Undefined: index registers omitted, `ov_min_idx`/`ov_max_idx` tied to 0; min/max values and timing unchanged.

## Structure
- Shared package: state encoding constants (IDLE=0, LOAD=1, CMP_MIN=2, CMP_MAX=3, DONE=4) and 3-bit state width.
- One sub-module: `CmpZelg` instance `u_cmp`, operand mux selects y=min in CMP_MIN, y=max in CMP_MAX; `o_zero`/`o_equal` unused.

## Test plan
- p_WIDTH=8, len=4, data 5,2,9,2 → min=2 idx1, max=9 idx2, `o_done` 11 cycles after start, one cycle wide.
- len=1, data 7 → min=max=7, both idx 0, `o_done` 2 cycles after start.
- len=0 → `o_done` next cycle, `o_empty`=1, min=max=0; following len=2 scan clears `o_empty`.
- len=3, data 0xFF ×3 with 2-cycle `i_valid` gaps and `i_start` pulsed mid-scan → min=max=0xFF, idx 0/0, extra start ignored, no data lost.
- Reset asserted during CMP_MIN of element 2 → all outputs 0 asynchronously; new scan 1,0 yields min=0 idx1, max=1 idx0.
- Build without `CMP_MINMAX_IDX_EN`, rerun scenario 1 → same min/max and cycle counts, indices 0.
